// File: rtl/bp_pkg.sv
// Branch predictor shared definitions: opcodes, 2-bit counter encodings,
// the in-flight prediction record and small helpers.
package bp_pkg;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

    // Widest PHT index the in-flight record can carry.
    localparam int unsigned IDX_W_MAX = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    // Prediction made in IF, carried alongside the branch into ID.
    typedef struct packed {
        logic                 valid;
        logic                 taken;
        logic [IDX_W_MAX-1:0] idx;
    } bp_rec_t;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == BEQ) || (op == BNE);
    endfunction

    // Saturating step of a 2-bit confidence counter.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        nxt = cnt;
        if (up && (cnt != 2'(ST))) begin
            nxt = cnt + 2'd1;
        end else if (!up && (cnt != 2'(SNT))) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_ctrl_if.sv
// Pipeline <-> branch predictor signal bundle.
//   master : pipeline side (drives IF/ID info, receives prediction/redirect)
//   slave  : predictor side (bp_ctrl)
interface bp_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [5:0]       if_opcode;
    logic             pred_taken;
    logic [5:0]       id_opcode;
    logic             id_equal;
    logic [31:0]      id_target;
    logic [31:0]      id_pc_plus4;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output stall, if_valid, if_pc, if_opcode,
        output id_opcode, id_equal, id_target, id_pc_plus4,
        input  pred_taken, flush, redirect_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  stall, if_valid, if_pc, if_opcode,
        input  id_opcode, id_equal, id_target, id_pc_plus4,
        output pred_taken, flush, redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W two-bit saturating counters.
//   clk, rst_n   : clock, synchronous active-low reset (all entries -> WNT)
//   rd_idx       : lookup index, rd_cnt_c is the combinational read-out
//   upd_en       : apply one saturating step at upd_idx toward upd_taken
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt_c,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0] tbl_q [DEPTH];

    // Read returns the pre-update value when read and write hit the same entry.
    assign rd_cnt_c = tbl_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= 2'(WNT);
            end
        end else if (upd_en) begin
            tbl_q[upd_idx] <= sat_step(tbl_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// Branch predictor controller for BEQ/BNE: predicts in IF from a 2-bit PHT,
// resolves in ID, flushes/redirects on mispredict and keeps statistics.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bp_ctrl_if slave (IF/ID inputs, prediction, flush, counters)
// Build option: define BP_GSHARE_EN to XOR the PC index with a global
// history register updated at resolution (non-speculative).
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    bp_ctrl_if.slave bus
);
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       rd_cnt;
    logic             if_branch;
    logic             pred_c;
    logic             resolve_c;
    logic             actual_c;
    logic             mispredict_c;
    bp_rec_t          rec_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             unused_pc_bits;

    assign pc_idx         = bus.if_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign lookup_idx = pc_idx ^ ghr_q;

    // History advances only with resolved outcomes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (resolve_c) begin
            ghr_q <= {ghr_q[IDX_W-2:0], actual_c};
        end
    end
`else
    assign lookup_idx = pc_idx;
`endif

    assign upd_idx = IDX_W'(rec_q.idx);

    bp_pht #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (lookup_idx),
        .rd_cnt_c  (rd_cnt),
        .upd_en    (resolve_c),
        .upd_idx   (upd_idx),
        .upd_taken (actual_c)
    );

    // IF-side prediction; forced low while reset is asserted.
    assign if_branch = bus.if_valid && is_branch(bus.if_opcode);
    assign pred_c    = rst_n && if_branch && rd_cnt[1];

    // ID-side resolution of the branch carried in the record.
    assign resolve_c    = rst_n && rec_q.valid && !bus.stall && is_branch(bus.id_opcode);
    assign actual_c     = (bus.id_opcode == BEQ) ? bus.id_equal : !bus.id_equal;
    assign mispredict_c = resolve_c && (actual_c != rec_q.taken);

    assign bus.pred_taken  = pred_c;
    assign bus.flush       = mispredict_c;
    assign bus.redirect_pc = !mispredict_c ? 32'd0 :
                             (actual_c ? bus.id_target : bus.id_pc_plus4);
    assign bus.br_cnt      = br_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;

    // In-flight record and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rec_q      <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (!bus.stall) begin
                if (mispredict_c) begin
                    rec_q <= '0;
                end else begin
                    rec_q <= '{valid: if_branch,
                               taken: pred_c,
                               idx:   IDX_W_MAX'(lookup_idx)};
                end
            end
            if (resolve_c && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispredict_c && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_bp_ctrl;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int          NENT  = 1 << IDX_W;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam logic [5:0]  OBEQ  = 6'b000100;
    localparam logic [5:0]  OBNE  = 6'b000101;
    localparam logic [5:0]  ONOP  = 6'b000000;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    bp_ctrl_if #(.CNT_W(CNT_W)) bus ();

    bp_ctrl #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integers per table entry and record field.
    int m_pht [NENT];
    bit m_rv;
    bit m_rt;
    int m_ridx;
    int m_ghr;
    int m_br;
    int m_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic st, input logic iv, input logic [31:0] pc,
                          input logic [5:0] iop, input logic [5:0] idop, input logic eq,
                          input logic [31:0] tgt, input logic [31:0] pc4);
        bus.stall       = st;
        bus.if_valid    = iv;
        bus.if_pc       = pc;
        bus.if_opcode   = iop;
        bus.id_opcode   = idop;
        bus.id_equal    = eq;
        bus.id_target   = tgt;
        bus.id_pc_plus4 = pc4;
    endtask

    task automatic m_eval(output bit ifbr, output bit pred, output bit res, output bit act,
                          output bit mis, output logic [31:0] red, output int idx);
        bit id_br;
        ifbr = bus.if_valid && (bus.if_opcode == OBEQ || bus.if_opcode == OBNE);
        idx  = int'((bus.if_pc >> 2) & 32'(NENT - 1));
`ifdef BP_GSHARE_EN
        idx  = idx ^ m_ghr;
`endif
        pred  = rst_n && ifbr && (m_pht[idx] >= 2);
        id_br = (bus.id_opcode == OBEQ) || (bus.id_opcode == OBNE);
        res   = rst_n && m_rv && !bus.stall && id_br;
        act   = (bus.id_opcode == OBEQ) ? bus.id_equal : !bus.id_equal;
        mis   = res && (act != m_rt);
        red   = !mis ? 32'd0 : (act ? bus.id_target : bus.id_pc_plus4);
    endtask

    task automatic m_commit();
        bit ifbr, pred, res, act, mis;
        logic [31:0] red;
        int idx;
        m_eval(ifbr, pred, res, act, mis, red, idx);
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) m_pht[i] = 1;
            m_rv = 0; m_rt = 0; m_ridx = 0; m_ghr = 0; m_br = 0; m_miss = 0;
        end else begin
            if (res) begin
                if (act) m_pht[m_ridx] = (m_pht[m_ridx] == 3) ? 3 : m_pht[m_ridx] + 1;
                else     m_pht[m_ridx] = (m_pht[m_ridx] == 0) ? 0 : m_pht[m_ridx] - 1;
                m_br  = (m_br == CMAX) ? CMAX : m_br + 1;
                m_ghr = ((m_ghr << 1) | int'(act)) & (NENT - 1);
                if (mis) m_miss = (m_miss == CMAX) ? CMAX : m_miss + 1;
            end
            if (!bus.stall) begin
                if (mis) m_rv = 0;
                else begin
                    m_rv = ifbr; m_rt = pred; m_ridx = idx;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ifbr, pred, res, act, mis;
        logic [31:0] red;
        int idx;
        m_eval(ifbr, pred, res, act, mis, red, idx);
        check({tag, "_pred"},  32'(bus.pred_taken), 32'(pred));
        check({tag, "_flush"}, 32'(bus.flush),      32'(mis));
        check({tag, "_redir"}, bus.redirect_pc,     red);
        check({tag, "_br"},    32'(bus.br_cnt),     32'(m_br));
        check({tag, "_miss"},  32'(bus.miss_cnt),   32'(m_miss));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 32'd0, ONOP, ONOP, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        if_valid;
        logic [31:0] if_pc;
        logic [5:0]  if_op;
        logic [5:0]  id_op;
        logic        id_eq;
        logic        exp_pred;
        logic        exp_flush;
        logic [31:0] exp_red;
        int          exp_br;
        int          exp_miss;
        int          exp_pht0;
    } vec_t;

    vec_t vecs [11];

    initial begin
        n_chk  = 0;
        n_pass = 0;

        // Fresh-reset BEQ at 0x40 (index 0) taken four times, then a correctly
        // predicted not-taken BNE at 0x44 (index 1). Target 0x100, fall-through 0x44.
        vecs[0]  = '{1'b1, 32'h40, OBEQ, ONOP, 1'b0, 1'b0, 1'b0, 32'h0,   0, 0, 1};
        vecs[1]  = '{1'b0, 32'h0,  ONOP, OBEQ, 1'b1, 1'b0, 1'b1, 32'h100, 0, 0, 1};
        vecs[2]  = '{1'b1, 32'h40, OBEQ, ONOP, 1'b0, 1'b1, 1'b0, 32'h0,   1, 1, 2};
        vecs[3]  = '{1'b0, 32'h0,  ONOP, OBEQ, 1'b1, 1'b0, 1'b0, 32'h0,   1, 1, 2};
        vecs[4]  = '{1'b1, 32'h40, OBEQ, ONOP, 1'b0, 1'b1, 1'b0, 32'h0,   2, 1, 3};
        vecs[5]  = '{1'b0, 32'h0,  ONOP, OBEQ, 1'b1, 1'b0, 1'b0, 32'h0,   2, 1, 3};
        vecs[6]  = '{1'b1, 32'h40, OBEQ, ONOP, 1'b0, 1'b1, 1'b0, 32'h0,   3, 1, 3};
        vecs[7]  = '{1'b0, 32'h0,  ONOP, OBEQ, 1'b1, 1'b0, 1'b0, 32'h0,   3, 1, 3};
        vecs[8]  = '{1'b1, 32'h40, ONOP, ONOP, 1'b0, 1'b0, 1'b0, 32'h0,   4, 1, 3};
        vecs[9]  = '{1'b1, 32'h44, OBNE, ONOP, 1'b0, 1'b0, 1'b0, 32'h0,   4, 1, 3};
        vecs[10] = '{1'b0, 32'h0,  ONOP, OBNE, 1'b1, 1'b0, 1'b0, 32'h0,   4, 1, 3};

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 32'd0, ONOP, ONOP, 1'b0, 32'd0, 32'd0);
        tick();
        #3;
        check("rst_pred",  32'(bus.pred_taken), 32'd0);
        check("rst_flush", 32'(bus.flush),      32'd0);
        check("rst_redir", bus.redirect_pc,     32'd0);
        tick();
        check("rst_br",    32'(bus.br_cnt),     32'd0);
        check("rst_miss",  32'(bus.miss_cnt),   32'd0);
        rst_n = 1'b1;

`ifndef BP_GSHARE_EN
        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            set_in(1'b0, vecs[i].if_valid, vecs[i].if_pc, vecs[i].if_op, vecs[i].id_op,
                   vecs[i].id_eq, 32'h100, 32'h44);
            #3;
            check($sformatf("vec%0d_pred", i),  32'(bus.pred_taken),     32'(vecs[i].exp_pred));
            check($sformatf("vec%0d_flush", i), 32'(bus.flush),          32'(vecs[i].exp_flush));
            check($sformatf("vec%0d_redir", i), bus.redirect_pc,         vecs[i].exp_red);
            check($sformatf("vec%0d_br", i),    32'(bus.br_cnt),         32'(vecs[i].exp_br));
            check($sformatf("vec%0d_miss", i),  32'(bus.miss_cnt),       32'(vecs[i].exp_miss));
            check($sformatf("vec%0d_pht0", i),  32'(dut.u_pht.tbl_q[0]), 32'(vecs[i].exp_pht0));
            tick();
        end
        check("vec_end_pht1", 32'(dut.u_pht.tbl_q[1]), 32'd0);

        // Stall held three cycles over a mispredicting branch in ID.
        do_reset();
        set_in(1'b0, 1'b1, 32'h40, OBEQ, ONOP, 1'b0, 32'h200, 32'h44);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 32'h0, ONOP, OBEQ, 1'b1, 32'h200, 32'h44);
            #3;
            check($sformatf("stall%0d_flush", i), 32'(bus.flush),  32'd0);
            check($sformatf("stall%0d_redir", i), bus.redirect_pc, 32'd0);
            tick();
            check($sformatf("stall%0d_br", i),   32'(bus.br_cnt),         32'd0);
            check($sformatf("stall%0d_pht0", i), 32'(dut.u_pht.tbl_q[0]), 32'd1);
        end
        set_in(1'b0, 1'b0, 32'h0, ONOP, OBEQ, 1'b1, 32'h200, 32'h44);
        #3;
        check("stall_rel_flush", 32'(bus.flush),  32'd1);
        check("stall_rel_redir", bus.redirect_pc, 32'h200);
        tick();
        set_in(1'b0, 1'b0, 32'h0, ONOP, ONOP, 1'b0, 32'h0, 32'h0);
        #3;
        check("stall_post_br",   32'(bus.br_cnt),         32'd1);
        check("stall_post_miss", 32'(bus.miss_cnt),       32'd1);
        check("stall_post_pht0", 32'(dut.u_pht.tbl_q[0]), 32'd2);
        tick();

        // Mispredict kills a younger BNE sitting in IF.
        do_reset();
        set_in(1'b0, 1'b1, 32'h40, OBEQ, ONOP, 1'b0, 32'h300, 32'h44);
        tick();
        set_in(1'b0, 1'b1, 32'h44, OBNE, OBEQ, 1'b1, 32'h300, 32'h44);
        #3;
        check("kill_pred",  32'(bus.pred_taken), 32'd0);
        check("kill_flush", 32'(bus.flush),      32'd1);
        tick();
        set_in(1'b0, 1'b0, 32'h0, ONOP, OBNE, 1'b0, 32'h500, 32'h48);
        #3;
        check("kill_next_flush", 32'(bus.flush), 32'd0);
        tick();
        check("kill_br",   32'(bus.br_cnt),         32'd1);
        check("kill_pht1", 32'(dut.u_pht.tbl_q[1]), 32'd1);

        // Lookup of index 3 in the same cycle index 3 is updated.
        do_reset();
        set_in(1'b0, 1'b1, 32'h4C, OBEQ, ONOP, 1'b0, 32'h80, 32'h50);
        tick();
        set_in(1'b0, 1'b1, 32'h4C, OBEQ, OBEQ, 1'b1, 32'h80, 32'h50);
        #3;
        check("byp_same_pred",  32'(bus.pred_taken), 32'd0);
        check("byp_same_flush", 32'(bus.flush),      32'd1);
        tick();
        set_in(1'b0, 1'b1, 32'h4C, OBEQ, ONOP, 1'b0, 32'h80, 32'h50);
        #3;
        check("byp_next_pred", 32'(bus.pred_taken), 32'd1);
        tick();

        // Reset landing on an in-flight branch discards it.
        do_reset();
        set_in(1'b0, 1'b1, 32'h40, OBEQ, ONOP, 1'b0, 32'h90, 32'h44);
        tick();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, ONOP, OBEQ, 1'b1, 32'h90, 32'h44);
        #3;
        check("rstfly_flush", 32'(bus.flush), 32'd0);
        tick();
        rst_n = 1'b1;
        #3;
        check("rstfly_after_flush", 32'(bus.flush), 32'd0);
        tick();
        check("rstfly_br",   32'(bus.br_cnt),         32'd0);
        check("rstfly_pht0", 32'(dut.u_pht.tbl_q[0]), 32'd1);
`else
        // Global history after outcomes T,T,N, then an indexed lookup at 0x40.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 32'h40, OBEQ, ONOP, 1'b0, 32'h100, 32'h44);
            check_model($sformatf("gs_if%0d", i));
            tick();
            set_in(1'b0, 1'b0, 32'h0, ONOP, OBEQ, (i < 2), 32'h100, 32'h44);
            check_model($sformatf("gs_id%0d", i));
            tick();
        end
        check("gs_ghr", 32'(dut.ghr_q), 32'h6);
        set_in(1'b0, 1'b1, 32'h40, OBEQ, ONOP, 1'b0, 32'h100, 32'h44);
        #3;
        check("gs_idx", 32'(dut.lookup_idx), 32'h6);
        check_model("gs_look");
        tick();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [5:0]  iop;
            logic [5:0]  dop;
            logic [31:0] pc;
            int          r;
            rst_n = ($urandom_range(0, 149) != 0);
            r   = $urandom_range(0, 3);
            iop = (r == 0) ? OBEQ : (r == 1) ? OBNE : (r == 2) ? 6'($urandom) : ONOP;
            r   = $urandom_range(0, 4);
            dop = (r < 2) ? OBEQ : (r < 4) ? OBNE : 6'($urandom);
            pc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h40 + 32'($urandom_range(0, 15)) * 4;
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, pc, iop, dop,
                   1'($urandom), $urandom, $urandom);
            #3;
            check_model("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
